action_fetch: RTL

- Read-side sequencer for the action RAM (8-bit address, 16-bit data, registered read, no read enable).
- On `start`, streams `length` consecutive action words beginning at `start_address` out through a valid/ready interface to the game-logic consumer.
- Covers the RAM's one-cycle read latency and consumer back-pressure with a 2-entry output buffer.
- Issues no RAM writes; the write port stays with the loader side.

---
 rtl/action_fetch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/action_fetch.sv
// Read-side sequencer for the action RAM: streams a run of consecutive action
// words out through a valid/ready port, absorbing RAM latency in a 2-entry buffer.
module action_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_address,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_read_address,
    input  logic [DATA_WIDTH-1:0] ram_d_out,
    output logic                  act_valid,
    input  logic                  act_ready,
    output logic [DATA_WIDTH-1:0] act_data
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FINISH
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   issue_count;
    logic [ADDR_WIDTH:0]   accept_count;
    logic                  vld_p1;
    logic [1:0]            occ;
    logic [1:0]            occ_n;
    logic [2:0]            credit_used;
    logic [DATA_WIDTH-1:0] tail_data;
    logic                  accept;
    logic                  issue_p0;
    logic                  capture_to_head;

    // A word leaving the buffer this cycle frees its slot in time for a read
    // issued now, which keeps the stream gap-free with only two entries.
    always_comb begin
        accept      = act_valid && act_ready;
        credit_used = {1'b0, occ} + {2'b00, vld_p1};
        issue_p0    = (state == FETCH) &&
                      ((credit_used < 3'd2) || (accept && (credit_used == 3'd2)));
        capture_to_head = (occ == 2'd0) || ((occ == 2'd1) && accept);
        occ_n = occ;
        case ({accept, vld_p1})
            2'b10:   occ_n = occ - 2'd1;
            2'b01:   occ_n = occ + 2'd1;
            default: occ_n = occ;
        endcase
    end

    // p0: address presented to the RAM; p1: RAM word valid, captured at this edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            ram_read_address <= '0;
            issue_count      <= '0;
            accept_count     <= '0;
            vld_p1           <= 1'b0;
            occ              <= 2'd0;
            act_valid        <= 1'b0;
        end else begin
            done      <= 1'b0;
            vld_p1    <= issue_p0;
            occ       <= occ_n;
            act_valid <= (occ_n != 2'd0);
            if (accept)
                accept_count <= accept_count - 1'b1;
            if (issue_p0) begin
                ram_read_address <= ram_read_address + 1'b1;
                issue_count      <= issue_count - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            state            <= FETCH;
                            busy             <= 1'b1;
                            ram_read_address <= start_address;
                            issue_count      <= length;
                            accept_count     <= length;
                        end else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue_p0 && (issue_count == 1))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (accept && (accept_count == 1)) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Abort drops everything in flight and leaves without a done pulse.
            if (abort && busy) begin
                state     <= IDLE;
                busy      <= 1'b0;
                done      <= 1'b0;
                vld_p1    <= 1'b0;
                occ       <= 2'd0;
                act_valid <= 1'b0;
            end
        end
    end

    // Buffer: act_data is the head entry, tail_data the second entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            act_data <= '0;
        end else begin
            if (vld_p1 && capture_to_head)
                act_data <= ram_d_out;
            else if (accept && (occ == 2'd2))
                act_data <= tail_data;
            if (vld_p1 && !capture_to_head)
                tail_data <= ram_d_out;
        end
    end

endmodule
